// File: rtl/pipelined_addsub_if.sv
// Operand/result bus of the pipelined adder/subtractor.
// Both sides use valid/ready: a beat moves only on a rising clk edge where
// valid and ready are both 1. A producer holds valid and its data stable
// until that edge. ready may depend combinationally on the other side.
interface pipelined_addsub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, s, co, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, s, co, ovf, zero
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/sub, one CHUNK-bit slice per stage.
// Optional feature: define ADDSUB_SATURATE_EN to clamp s on signed overflow.
module pipelined_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input logic               clk,
  input logic               rst,
  pipelined_addsub_if.slave bus
);
  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("pipelined_addsub: WIDTH must be a non-zero multiple of CHUNK");
  end

  // Stage registers; index k holds the state after stage k has run.
  logic             v_r [STAGES];
  logic             c_r [STAGES];
  logic [WIDTH-1:0] a_r [STAGES];
  logic [WIDTH-1:0] b_r [STAGES];
  logic [WIDTH-1:0] s_r [STAGES];
  logic             ovf_r;
  logic             zero_r;

  // Stage inputs and the slice result each stage produces.
  logic             v_n   [STAGES];
  logic             cin   [STAGES];
  logic             c_n   [STAGES];
  logic [WIDTH-1:0] a_n   [STAGES];
  logic [WIDTH-1:0] b_n   [STAGES];
  logic [WIDTH-1:0] s_n   [STAGES];
  logic [CHUNK:0]   slice_sum [STAGES];

  logic             adv;
  logic [WIDTH-1:0] raw_s;
  logic             raw_co;
  logic             msb_cin;
  logic             raw_ovf;
  logic [WIDTH-1:0] final_s;

  assign adv = bus.out_ready | ~v_r[LAST];

  // Stage 0 takes the live operands with b pre-inverted for subtraction;
  // later stages take the operands delayed by the previous stage.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      v_n[k]       = 1'b0;
      cin[k]       = 1'b0;
      a_n[k]       = '0;
      b_n[k]       = '0;
      s_n[k]       = '0;
      c_n[k]       = 1'b0;
      slice_sum[k] = '0;
    end
    v_n[0] = bus.in_valid;
    cin[0] = bus.sub;
    a_n[0] = bus.a;
    b_n[0] = bus.b ^ {WIDTH{bus.sub}};
    s_n[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      v_n[k] = v_r[k-1];
      cin[k] = c_r[k-1];
      a_n[k] = a_r[k-1];
      b_n[k] = b_r[k-1];
      s_n[k] = s_r[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      slice_sum[k] = {1'b0, a_n[k][k*CHUNK +: CHUNK]}
                   + {1'b0, b_n[k][k*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, cin[k]};
      s_n[k][k*CHUNK +: CHUNK] = slice_sum[k][CHUNK-1:0];
      c_n[k] = slice_sum[k][CHUNK];
    end
  end

  // Carry into the MSB is recovered from the MSB sum bit and its operands.
  always_comb begin
    raw_s   = s_n[LAST];
    raw_co  = c_n[LAST];
    msb_cin = a_n[LAST][WIDTH-1] ^ b_n[LAST][WIDTH-1] ^ raw_s[WIDTH-1];
    raw_ovf = msb_cin ^ raw_co;
  end

`ifdef ADDSUB_SATURATE_EN
  // A wrapped negative-looking sum means the true result overflowed upward.
  always_comb begin
    final_s = raw_s;
    if (raw_ovf) begin
      if (raw_s[WIDTH-1]) final_s = {1'b0, {(WIDTH-1){1'b1}}};
      else                final_s = {1'b1, {(WIDTH-1){1'b0}}};
    end
  end
`else
  assign final_s = raw_s;
`endif

  // Data registers load only for valid beats so idle stages keep quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_r[k] <= 1'b0;
        c_r[k] <= 1'b0;
        a_r[k] <= '0;
        b_r[k] <= '0;
        s_r[k] <= '0;
      end
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        v_r[k] <= v_n[k];
        if (v_n[k]) begin
          c_r[k] <= c_n[k];
          a_r[k] <= a_n[k];
          b_r[k] <= b_n[k];
          s_r[k] <= (k == LAST) ? final_s : s_n[k];
        end
      end
      if (v_n[LAST]) begin
        ovf_r  <= raw_ovf;
        zero_r <= (final_s == '0);
      end
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = v_r[LAST];
  assign bus.s         = s_r[LAST];
  assign bus.co        = c_r[LAST];
  assign bus.ovf       = ovf_r;
  assign bus.zero      = zero_r;
endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub (WIDTH=8, CHUNK=4, two stages).
module tb_pipelined_addsub;
  localparam int WIDTH  = 8;
  localparam int CHUNK  = 4;
  localparam int STAGES = WIDTH / CHUNK;
  localparam int W      = WIDTH + 3;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;
    logic             zero;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  vec_t       tbl [12];
  logic [W-1:0] exp_q [$];
  int         acc_q [$];
  int         low_q [$];

  pipelined_addsub_if #(.WIDTH(WIDTH)) bus ();

  pipelined_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [7:0] a, input logic [7:0] b, input logic sub,
                         input logic [7:0] s_wrap, input logic [7:0] s_sat, input logic co,
                         input logic ovf, input logic z_wrap, input logic z_sat);
    tbl[i].a   = a;
    tbl[i].b   = b;
    tbl[i].sub = sub;
    tbl[i].co  = co;
    tbl[i].ovf = ovf;
`ifdef ADDSUB_SATURATE_EN
    tbl[i].s    = s_sat;
    tbl[i].zero = z_sat;
`else
    tbl[i].s    = s_wrap;
    tbl[i].zero = z_wrap;
`endif
  endtask

  task automatic drive_idle();
    bus.in_valid = 1'b0;
    bus.a        = WIDTH'($urandom_range(0, 255));
    bus.b        = WIDTH'($urandom_range(0, 255));
    bus.sub      = 1'($urandom_range(0, 1));
  endtask

  task automatic check_head(input string tag);
    logic [W-1:0] e;
    e = exp_q[0];
    check({tag, "_s"},    32'(bus.s),    32'(e[W-1:3]));
    check({tag, "_co"},   32'(bus.co),   32'(e[2]));
    check({tag, "_ovf"},  32'(bus.ovf),  32'(e[1]));
    check({tag, "_zero"}, 32'(bus.zero), 32'(e[0]));
  endtask

  // Driver + scoreboard: sends tbl[first +: n], holds out_ready low for
  // stall_len cycles starting at loop cycle stall_start.
  task automatic run_stream(input string name, input int first, input int n,
                            input int stall_start, input int stall_len);
    int sent;
    int got;
    int cyc;
    int low_cnt;
    sent    = 0;
    got     = 0;
    cyc     = 0;
    low_cnt = 0;
    while (got < n && cyc < 200) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= stall_start && cyc < stall_start + stall_len);
      if (!bus.out_ready) low_cnt++;
      if (sent < n) begin
        bus.in_valid = 1'b1;
        bus.a        = tbl[first+sent].a;
        bus.b        = tbl[first+sent].b;
        bus.sub      = tbl[first+sent].sub;
      end else begin
        drive_idle();
      end
      #1;
      if (!bus.out_ready) begin
        check($sformatf("%s_stall_ovalid_c%0d", name, cyc), 32'(bus.out_valid), 32'd1);
        check($sformatf("%s_stall_iready_c%0d", name, cyc), 32'(bus.in_ready), 32'd0);
        if (exp_q.size() > 0) check_head($sformatf("%s_hold_c%0d", name, cyc));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check($sformatf("%s_unexpected_out_c%0d", name, cyc), 32'd1, 32'd0);
        end else begin
          check_head($sformatf("%s_beat%0d", name, got));
          if (low_q[0] == low_cnt)
            check($sformatf("%s_lat%0d", name, got), 32'(cyc - acc_q[0]), 32'(STAGES));
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
          void'(low_q.pop_front());
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back({tbl[first+sent].s, tbl[first+sent].co,
                         tbl[first+sent].ovf, tbl[first+sent].zero});
        acc_q.push_back(cyc);
        low_q.push_back(low_cnt);
        sent++;
      end
      cyc++;
    end
    check({name, "_delivered"}, 32'(got), 32'(n));
    @(negedge clk);
    drive_idle();
    bus.out_ready = 1'b1;
    exp_q.delete();
    acc_q.delete();
    low_q.delete();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    //       idx a      b      sub  s_wrap s_sat  co    ovf   z_wrap z_sat
    set_vec(0,  8'd5,  8'd11, 1'b1, 8'hFA, 8'hFA, 1'b0, 1'b0, 1'b0, 1'b0);
    set_vec(1,  8'd13, 8'd3,  1'b1, 8'h0A, 8'h0A, 1'b1, 1'b0, 1'b0, 1'b0);
    set_vec(2,  8'd3,  8'd3,  1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    set_vec(3,  8'h7F, 8'h01, 1'b0, 8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);
    set_vec(4,  8'h80, 8'h01, 1'b1, 8'h7F, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0);
    set_vec(5,  8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    set_vec(6,  8'h12, 8'h34, 1'b0, 8'h46, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0);
    set_vec(7,  8'h20, 8'h30, 1'b1, 8'hF0, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_vec(8,  8'h80, 8'h80, 1'b0, 8'h00, 8'h80, 1'b1, 1'b1, 1'b1, 1'b0);
    set_vec(9,  8'h40, 8'h40, 1'b0, 8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);
    set_vec(10, 8'h7F, 8'hFF, 1'b1, 8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);
    set_vec(11, 8'hA5, 8'h5A, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);

    rst           = 1'b1;
    bus.out_ready = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_s",         32'(bus.s),         32'd0);
    check("rst_co",        32'(bus.co),        32'd0);
    check("rst_ovf",       32'(bus.ovf),       32'd0);
    check("rst_zero",      32'(bus.zero),      32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    @(negedge clk);
    rst = 1'b0;

    run_stream("sub_5_11",  0, 1, 1000, 0);
    run_stream("sub_pair",  1, 2, 1000, 0);
    run_stream("add_ovf",   3, 1, 1000, 0);
    run_stream("sub_ovf",   4, 1, 1000, 0);
    run_stream("ones_p1",   5, 1, 1000, 0);
    run_stream("stall6",    6, 6, 3, 3);

    // Reset with two beats in flight: nothing may emerge afterwards.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = tbl[6].a; bus.b = tbl[6].b; bus.sub = tbl[6].sub;
    #1;
    check("flush_accept0_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.a = tbl[11].a; bus.b = tbl[11].b; bus.sub = tbl[11].sub;
    rst = 1'b1;
    #1;
    check("flush_pre_ovalid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    #1;
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("flush_ovalid_c%0d", i), 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      #1;
    end
    check("flush_s",    32'(bus.s),    32'd0);
    check("flush_co",   32'(bus.co),   32'd0);
    check("flush_ovf",  32'(bus.ovf),  32'd0);
    check("flush_zero", 32'(bus.zero), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
Parametrised, pipelined two's-complement adder/subtractor; successor to the fixed 4-bit binary subtractor. Splits a WIDTH-bit operation into CHUNK-bit slices, one slice per pipeline stage, with the carry registered between stages. Accepts one operation per cycle through a valid/ready handshake. Produces the result and carry, signed-overflow and zero flags. Used as the datapath arithmetic unit wherever operand width exceeds single-cycle ripple timing.

Parameters:
WIDTH, 8, operand/result width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits computed per pipeline stage; STAGES = WIDTH/CHUNK (minimum 1).

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept an operand beat this cycle
a  input  WIDTH  minuend / addend
b  input  WIDTH  subtrahend / addend
sub  input  1  1 = a - b, 0 = a + b
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
s  output  WIDTH  result, modulo 2^WIDTH
co  output  1  carry out of MSB; for sub, 1 = no borrow (a >= b unsigned)
ovf  output  1  signed overflow
zero  output  1  s == 0

Behaviour:
- Arithmetic: s = a + (b XOR {WIDTH{sub}}) + sub, computed as STAGES slices. Stage k adds slice k using the carry registered by stage k-1; stage 0 carry-in = sub.
- co = carry out of bit WIDTH-1. ovf = carry into MSB XOR carry out of MSB. zero = (s == 0), evaluated on the final s.
- Operand slices not yet consumed are delayed alongside the pipeline; completed result slices are delayed so that all of s aligns with out_valid.
- Advance enable: adv = out_ready OR NOT out_valid. in_ready = adv (combinational).
- When adv = 1, every stage register loads from the stage before it, and the stage-0 valid bit loads in_valid. When adv = 0, all stages hold.
- A beat is accepted when in_valid AND in_ready. It is presented at the output exactly STAGES cycles after acceptance if no stall occurs. Each stall cycle adds one cycle.
- Throughput is one beat per cycle while out_ready = 1.
- Bubbles are not collapsed. Beat order is preserved.
- Outputs s, co, ovf and zero are stable while out_valid = 1 AND out_ready = 0.
- Reset (synchronous): all valid bits cleared, all data and carry registers cleared. After reset: out_valid = 0, s = 0, co = 0, ovf = 0, zero = 0, in_ready = 1.
- Reset mid-operation discards all in-flight beats; no partial result is emitted.
- Boundaries: a = b under sub gives s = 0, co = 1, zero = 1.
- Boundaries: all-ones + 1 gives s = 0, co = 1, ovf = 0.
- STAGES = 1 degenerates to a single registered adder with latency 1.

Optional Feature:
Macro ADDSUB_SATURATE_EN.
- Defined: when ovf = 1, s is clamped to the signed limit. Positive overflow gives 0 followed by all ones; negative overflow gives 1 followed by all zeros. co and ovf still report the raw unclamped values. zero reflects the clamped s.
- Not defined: s always wraps modulo 2^WIDTH. No clamp logic is synthesised.

Test Plan:
- Reset, then sub=1, a=8'd5, b=8'd11 with out_ready=1 -> after 2 cycles out_valid=1, s=8'hFA, co=0, ovf=0, zero=0.
- Sub cases, one per cycle: a=13, b=3 -> s=10, co=1; a=3, b=3 -> s=0, co=1, zero=1. Results arrive on consecutive cycles in order.
- Add a=8'h7F, b=8'h01 -> wrap build: s=8'h80, ovf=1, co=0; ADDSUB_SATURATE_EN build: s=8'h7F, ovf=1.
- Sub a=8'h80, b=8'h01 -> wrap build: s=8'h7F, ovf=1, co=1; saturate build: s=8'h80.
- Stream 6 beats with out_ready low for 3 cycles mid-stream -> in_ready=0 while the output is held; s is stable; no beat lost or duplicated; order preserved.
- Accept 2 beats, assert rst for 1 cycle before the first emerges -> no out_valid ever appears for those beats; outputs read 0; in_ready=1 on the cycle after reset.
